lut_bank_cfg: RTL and testbench

- Bank of N independent K-input lookup tables, configured through a serial shift chain that can be daisy-chained.
- Configuration is double-buffered. Bits shift into a shadow chain while the active configuration keeps driving the outputs. The shadow chain is committed atomically when the last bit arrives.
- Each LUT has a per-LUT mode bit that selects a combinational output or a registered output.
- This block is the clocked, parametrised successor to the team's single 4-input LUT. It is the logic tile for the programmable-fabric experiments.

---
 rtl/lut_bank_cfg_if.sv | 25 ++
 rtl/lut_bank_cfg.sv | 112 +++++++++++
 tb/tb_lut_bank_cfg.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_bank_cfg_if.sv
// Bus of one LUT bank: serial config chain and LUT addresses in, LUT results and chain tail out.
// Slave modport is the bank; no backpressure, the chain accepts a bit on any cycle i_cfg_valid is high.
interface lut_bank_cfg_if #(
    parameter int K = 4,
    parameter int N = 4
);
    logic           i_cfg_start;
    logic           i_cfg_valid;
    logic           i_cfg_bit;
    logic [N*K-1:0] i_lut_in;
    logic [N-1:0]   o_data;
    logic           o_cfg_out;
    logic           o_busy;
    logic           o_cfg_valid;

    modport slave (
        input  i_cfg_start, i_cfg_valid, i_cfg_bit, i_lut_in,
        output o_data, o_cfg_out, o_busy, o_cfg_valid
    );

    modport master (
        output i_cfg_start, i_cfg_valid, i_cfg_bit, i_lut_in,
        input  o_data, o_cfg_out, o_busy, o_cfg_valid
    );
endinterface

// File: rtl/lut_bank_cfg.sv
// Bank of N K-input LUTs configured through a double-buffered, daisy-chainable serial shift chain.
// Latency: comb-mode LUTs 0 cycles, registered-mode 1 cycle; no backpressure, bits taken whenever valid in LOAD.
module lut_bank_cfg #(
    parameter int K = 4,
    parameter int N = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lut_bank_cfg_if.slave bus
);
    localparam int TT       = 1 << K;
    localparam int W        = TT + 1;
    localparam int CFG_BITS = N * W;
    localparam int CW       = $clog2(CFG_BITS + 1);

    typedef enum logic [1:0] {
        S_UNCFG,
        S_LOAD,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [N-1:0]        oreg_q, oreg_d;
    logic                cfg_out_q, cfg_out_d;
    logic                cfg_valid_q, cfg_valid_d;

    logic [N-1:0]        lut_val;
    logic [N-1:0]        mode;

    for (genvar g = 0; g < N; g++) begin : g_lut
        logic [TT-1:0] tt;
        assign tt         = active_q[g*W +: TT];
        assign lut_val[g] = tt[bus.i_lut_in[g*K +: K]];
        assign mode[g]    = active_q[g*W + TT];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        oreg_d      = oreg_q;
        cfg_out_d   = cfg_out_q;
        cfg_valid_d = cfg_valid_q;

        // Output registers track the active config even while a reload is in flight.
        if (state_q == S_RUN || (state_q == S_LOAD && cfg_valid_q)) begin
            oreg_d = lut_val;
        end

        case (state_q)
            S_UNCFG: begin
                if (bus.i_cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.i_cfg_start) begin
                    cnt_d = '0;
                end else if (bus.i_cfg_valid) begin
                    shadow_d  = {bus.i_cfg_bit, shadow_q[CFG_BITS-1:1]};
                    cfg_out_d = shadow_q[0];
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CW'(CFG_BITS - 1)) begin
                        active_d    = shadow_d;
                        state_d     = S_RUN;
                        cfg_valid_d = 1'b1;
                        oreg_d      = '0;
                    end
                end
            end
            S_RUN: begin
                if (bus.i_cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_UNCFG;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_UNCFG;
            cnt_q       <= '0;
            shadow_q    <= '0;
            active_q    <= '0;
            oreg_q      <= '0;
            cfg_out_q   <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            oreg_q      <= oreg_d;
            cfg_out_q   <= cfg_out_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

    assign bus.o_data      = cfg_valid_q ? ((mode & oreg_q) | (~mode & lut_val)) : '0;
    assign bus.o_busy      = (state_q == S_LOAD);
    assign bus.o_cfg_out   = cfg_out_q;
    assign bus.o_cfg_valid = cfg_valid_q;
endmodule

// File: tb/tb_lut_bank_cfg.sv
// Two chained banks (A tail feeds B) driven by random and directed steps, checked against a bit-history model.
module tb_lut_bank_cfg;
    localparam int K  = 4;
    localparam int N  = 4;
    localparam int TT = 1 << K;
    localparam int W  = TT + 1;
    localparam int CB = N * W;

    logic  clk = 1'b0;
    logic  rst;
    int    n_asrt = 0;
    int    n_fail = 0;
    string phase  = "init";

    lut_bank_cfg_if #(.K(K), .N(N)) ifa ();
    lut_bank_cfg_if #(.K(K), .N(N)) ifb ();

    assign ifb.i_cfg_valid = ifa.i_cfg_valid;
    assign ifb.i_cfg_bit   = ifa.o_cfg_out;
    assign ifb.i_lut_in    = ifa.i_lut_in;

    lut_bank_cfg #(.K(K), .N(N)) u_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    lut_bank_cfg #(.K(K), .N(N)) u_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: each bank's chain is the list of every bit it ever accepted.
    // Shadow = last CB bits, chain tail = the bit CB+1 back (history is seeded with zeros).
    int          m_state  [2];
    int          m_cnt    [2];
    bit          m_valid  [2];
    bit [CB-1:0] m_active [2];
    bit [N-1:0]  m_reg    [2];
    bit          hist_a   [$];
    bit          hist_b   [$];

    function automatic bit hist_at(input int bk, input int back);
        if (bk == 0) return hist_a[hist_a.size() - back];
        return hist_b[hist_b.size() - back];
    endfunction

    task automatic model_reset();
        hist_a.delete();
        hist_b.delete();
        for (int i = 0; i < CB + 1; i++) begin
            hist_a.push_back(1'b0);
            hist_b.push_back(1'b0);
        end
        for (int bk = 0; bk < 2; bk++) begin
            m_state[bk]  = 0;
            m_cnt[bk]    = 0;
            m_valid[bk]  = 1'b0;
            m_active[bk] = '0;
            m_reg[bk]    = '0;
        end
    endtask

    task automatic bank_edge(input int bk, input bit st, input bit v, input bit b, input logic [N*K-1:0] lin);
        bit [N-1:0]  samp;
        bit [CB-1:0] sh;
        for (int n = 0; n < N; n++) samp[n] = m_active[bk][n*W + int'(lin[n*K +: K])];
        if (m_state[bk] == 2 || (m_state[bk] == 1 && m_valid[bk])) m_reg[bk] = samp;
        if (st) begin
            m_state[bk] = 1;
            m_cnt[bk]   = 0;
        end else if (m_state[bk] == 1 && v) begin
            if (bk == 0) hist_a.push_back(b);
            else         hist_b.push_back(b);
            m_cnt[bk]++;
            if (m_cnt[bk] == CB) begin
                for (int i = 0; i < CB; i++) sh[i] = hist_at(bk, CB - i);
                m_active[bk] = sh;
                m_state[bk]  = 2;
                m_valid[bk]  = 1'b1;
                m_reg[bk]    = '0;
            end
        end
    endtask

    task automatic model_edge(input bit st_a, input bit st_b, input bit v, input bit b, input logic [N*K-1:0] lin);
        bit b_b;
        b_b = hist_at(0, CB + 1);
        bank_edge(0, st_a, v, b, lin);
        bank_edge(1, st_b, v, b_b, lin);
    endtask

    function automatic logic [N-1:0] exp_data(input int bk, input logic [N*K-1:0] lin);
        logic [N-1:0] d;
        d = '0;
        if (m_valid[bk]) begin
            for (int n = 0; n < N; n++) begin
                if (m_active[bk][n*W + TT]) d[n] = m_reg[bk][n];
                else                        d[n] = m_active[bk][n*W + int'(lin[n*K +: K])];
            end
        end
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_bank(input int bk);
        string        nm;
        logic [N-1:0] d;
        logic         bz, cv, co;
        nm = (bk == 0) ? "A" : "B";
        if (bk == 0) begin
            d = ifa.o_data; bz = ifa.o_busy; cv = ifa.o_cfg_valid; co = ifa.o_cfg_out;
        end else begin
            d = ifb.o_data; bz = ifb.o_busy; cv = ifb.o_cfg_valid; co = ifb.o_cfg_out;
        end
        chk($sformatf("%s/%s o_busy", phase, nm), bz, m_state[bk] == 1);
        chk($sformatf("%s/%s o_cfg_valid", phase, nm), cv, m_valid[bk]);
        chk($sformatf("%s/%s o_cfg_out", phase, nm), co, hist_at(bk, CB + 1));
        chk($sformatf("%s/%s o_data", phase, nm), d, exp_data(bk, ifa.i_lut_in));
    endtask

    task automatic step(input bit st_a, input bit st_b, input bit v, input bit b,
                        input logic [N*K-1:0] lin, input bit r);
        rst             = r;
        ifa.i_cfg_start = st_a;
        ifb.i_cfg_start = st_b;
        ifa.i_cfg_valid = v;
        ifa.i_cfg_bit   = b;
        ifa.i_lut_in    = lin;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(st_a, st_b, v, b, lin);
        #1;
        check_bank(0);
        check_bank(1);
    endtask

    task automatic load_bits(input bit [CB-1:0] cfg, input int from, input int to);
        int i;
        bit v, b;
        i = from;
        while (i < to) begin
            v = ($urandom_range(0, 3) != 0);
            b = v ? cfg[i] : bit'($urandom_range(0, 1));
            step(1'b0, 1'b0, v, b, 16'($urandom), 1'b0);
            if (v) i++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, bit'(i % 2), bit'($urandom_range(0, 1)), 16'($urandom), 1'b0);
    endtask

    task automatic sweep();
        logic [K-1:0] a4;
        for (int a = 0; a < TT; a++) begin
            a4 = K'(a);
            step(1'b0, 1'b0, 1'b0, 1'b0, {N{a4}}, 1'b0);
        end
    endtask

    function automatic bit [CB-1:0] mk_cfg(input bit [TT-1:0] t0, input bit [TT-1:0] t1,
                                           input bit [TT-1:0] t2, input bit [TT-1:0] t3,
                                           input bit [N-1:0] md);
        bit [CB-1:0] c;
        bit [TT-1:0] t [N];
        t[0] = t0; t[1] = t1; t[2] = t2; t[3] = t3;
        for (int n = 0; n < N; n++) begin
            c[n*W +: TT] = t[n];
            c[n*W + TT]  = md[n];
        end
        return c;
    endfunction

    function automatic bit [CB-1:0] rand_cfg();
        bit [CB-1:0] c;
        for (int i = 0; i < CB; i++) c[i] = bit'($urandom_range(0, 1));
        return c;
    endfunction

    // After a C1 commit: LUT1 is registered parity, so it lags one cycle behind the address.
    task automatic basic_check(input string tag);
        phase = tag;
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        ifa.i_lut_in = 16'hF077;
        #1;
        chk({tag, " and4@7"}, ifa.o_data[0], 1'b0);
        chk({tag, " parity before edge"}, ifa.o_data[1], 1'b0);
        chk({tag, " zero lut"}, ifa.o_data[2], 1'b0);
        chk({tag, " ones lut"}, ifa.o_data[3], 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'hF077, 1'b0);
        chk({tag, " parity after edge"}, ifa.o_data[1], 1'b1);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, " A o_data"}, ifa.o_data, 0);
        chk({tag, " A o_cfg_valid"}, ifa.o_cfg_valid, 0);
        chk({tag, " A o_busy"}, ifa.o_busy, 0);
        chk({tag, " A o_cfg_out"}, ifa.o_cfg_out, 0);
        chk({tag, " B o_data"}, ifb.o_data, 0);
        chk({tag, " B o_cfg_valid"}, ifb.o_cfg_valid, 0);
    endtask

    bit [CB-1:0] c1, c2, c3, d1, d2;

    initial begin
        c1 = mk_cfg(16'h8000, 16'h6996, 16'h0000, 16'hFFFF, 4'b0010);
        c2 = mk_cfg(~16'h8000, ~16'h6996, ~16'h0000, ~16'hFFFF, 4'b0010);
        c3 = rand_cfg();
        d1 = rand_cfg();
        d2 = rand_cfg();

        phase = "reset_idle";
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        reset_check("after reset");
        idle(20);
        reset_check("idle no start");

        phase = "basic_load";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        chk("busy after start", ifa.o_busy, 1'b1);
        load_bits(c1, 0, CB);
        chk("commit cfg_valid", ifa.o_cfg_valid, 1'b1);
        chk("commit busy low", ifa.o_busy, 1'b0);
        basic_check("basic");
        sweep();

        phase = "shadow_iso";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(c2, 0, 30);
        idle(6);
        ifa.i_lut_in = 16'hFFFF;
        #1;
        chk("old and4@F during reload", ifa.o_data[0], 1'b1);
        chk("old zero during reload", ifa.o_data[2], 1'b0);
        chk("old ones during reload", ifa.o_data[3], 1'b1);
        load_bits(c2, 30, CB);
        ifa.i_lut_in = 16'hF077;
        #1;
        chk("inv and4@7", ifa.o_data[0], 1'b1);
        chk("inv zero", ifa.o_data[2], 1'b1);
        chk("inv ones", ifa.o_data[3], 1'b0);
        sweep();

        phase = "restart";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(c3, 0, 10);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b0);
        load_bits(c3, 0, CB - 1);
        chk("restart 67 bits busy", ifa.o_busy, 1'b1);
        load_bits(c3, CB - 1, CB);
        chk("restart 68 bits busy", ifa.o_busy, 1'b0);
        sweep();

        phase = "daisy";
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(d1, 0, CB);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(d2, 0, CB);
        chk("daisy B cfg_valid", ifb.o_cfg_valid, 1'b1);
        sweep();
        idle(8);

        phase = "reset_run";
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b1);
        reset_check("reset in run");
        idle(4);
        phase = "reset_load";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(c1, 0, 40);
        step(1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b1);
        reset_check("reset mid load");
        idle(3);
        phase = "reload_after_reset";
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom), 1'b0);
        load_bits(c1, 0, CB);
        basic_check("post reset");
        sweep();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
